// File: rtl/calc_multicycle.sv
// ============================================================================
// Module   : calc_multicycle
// Purpose  : Multi-cycle accumulator-style calculator core. Instructions and
//            data share one memory port with a request/ready handshake.
//            The core supports ALU-immediate ops, load/store, branches and
//            halt/illegal detection. It also has a retired-instruction
//            counter and a debug register read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_multicycle #(
  parameter int DATA_W = 32,
  parameter int NREG   = 4,
  parameter int ADDR_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [31:0]       MemRData,
  input  logic              MemReady,
  input  logic [3:0]        DbgSel,
  output logic [DATA_W-1:0] DbgData,
  output logic [ADDR_W-1:0] PC,
  output logic [31:0]       InstrAtual,
  output logic              Halted,
  output logic              Illegal,
  output logic [31:0]       Retired
);

  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_SUBI = 4'h2;
  localparam logic [3:0] OP_ANDI = 4'h3;
  localparam logic [3:0] OP_ORI  = 4'h4;
  localparam logic [3:0] OP_XORI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQZ = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] npc_q, npc_d;      // PC of the next instruction, resolved in DECODE
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       retired_q, retired_d;
  logic [DATA_W-1:0] res_q, res_d;      // ALU result or effective address
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;
  logic [DATA_W-1:0] regs_q [1:NREG-1]; // R0 is hard-wired zero and has no storage

  logic [3:0]        opcode, ra_idx, rd_idx;
  logic [DATA_W-1:0] imm_ext, ra_val, rd_val, alu_res;
  logic [ADDR_W-1:0] imm_addr, pc_inc, branch_pc;
  logic              is_alu, is_illegal;
  logic              wr_en;
  logic [3:0]        wr_idx;
  logic [DATA_W-1:0] wr_data;

  assign opcode     = ir_q[31:28];
  assign ra_idx     = ir_q[27:24];
  assign rd_idx     = ir_q[23:20];
  assign imm_ext    = DATA_W'($signed(ir_q[19:0]));
  assign imm_addr   = ADDR_W'($signed(ir_q[19:0]));
  assign pc_inc     = pc_q + ADDR_W'(1);
  assign is_alu     = (opcode >= OP_ADDI) && (opcode <= OP_XORI);
  assign is_illegal = (opcode >= 4'hA) && (opcode <= 4'hE);

  // Register read ports: both operands plus the debug port; absent indices read 0.
  always_comb begin
    ra_val  = '0;
    rd_val  = '0;
    DbgData = '0;
    for (int i = 1; i < NREG; i++) begin
      if (ra_idx == 4'(i)) ra_val  = regs_q[i];
      if (rd_idx == 4'(i)) rd_val  = regs_q[i];
      if (DbgSel == 4'(i)) DbgData = regs_q[i];
    end
  end

  // ALU: loads and stores reuse the adder for the effective address.
  always_comb begin
    alu_res = ra_val + imm_ext;
    case (opcode)
      OP_SUBI: alu_res = ra_val - imm_ext;
      OP_ANDI: alu_res = ra_val & imm_ext;
      OP_ORI:  alu_res = ra_val | imm_ext;
      OP_XORI: alu_res = ra_val ^ imm_ext;
      default: ;
    endcase
  end

  // Next-PC selection for sequential flow, BEQZ and JMP.
  always_comb begin
    branch_pc = pc_inc;
    if (opcode == OP_BEQZ && ra_val == '0) begin
      branch_pc = pc_inc + imm_addr;
    end else if (opcode == OP_JMP) begin
      branch_pc = imm_addr;
    end
  end

  // Next-state logic. Memory outputs are registered and preloaded on entry to
  // FETCH/MEM, so they stay stable through wait states and drop right after reset.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    ir_d      = ir_q;
    res_d     = res_q;
    retired_d = retired_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    wr_en     = 1'b0;
    wr_idx    = rd_idx;
    wr_data   = res_q;
    case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          // Only reached right after reset: issue the first fetch.
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc_q;
        end else if (MemReady) begin
          ir_d    = MemRData;
          req_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        res_d = alu_res;
        npc_d = branch_pc;
        if (opcode == OP_HALT || is_illegal) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          illegal_d = is_illegal;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (opcode == OP_LD || opcode == OP_ST) begin
          state_d = S_MEM;
          req_d   = 1'b1;
          we_d    = (opcode == OP_ST);
          addr_d  = ADDR_W'(res_q);
          wdata_d = rd_val;
        end else begin
          wr_en     = is_alu;
          pc_d      = npc_q;
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
          req_d     = 1'b1;
          we_d      = 1'b0;
          addr_d    = npc_q;
        end
      end
      S_MEM: begin
        if (MemReady) begin
          wr_en     = (opcode == OP_LD);
          wr_data   = DATA_W'(MemRData);
          pc_d      = npc_q;
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
          req_d     = 1'b1;
          we_d      = 1'b0;
          addr_d    = npc_q;
        end
      end
      S_HALT: begin
        req_d = 1'b0;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State and control registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      npc_q     <= '0;
      ir_q      <= '0;
      res_q     <= '0;
      retired_q <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      npc_q     <= npc_d;
      ir_q      <= ir_d;
      res_q     <= res_d;
      retired_q <= retired_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Register file write; writes to R0 or indices >= NREG match no entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wr_en && wr_idx == 4'(i)) begin
          regs_q[i] <= wr_data;
        end
      end
    end
  end

  assign MemReq     = req_q;
  assign MemWe      = we_q;
  assign MemAddr    = addr_q;
  assign MemWData   = wdata_q;
  assign PC         = pc_q;
  assign InstrAtual = ir_q;
  assign Halted     = halted_q;
  assign Illegal    = illegal_q;
  assign Retired    = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_multicycle.sv
// ============================================================================
// Module   : tb_calc_multicycle
// Purpose  : Self-checking bench for calc_multicycle. It has a memory
//            responder with wait states, a vector table, directed corner
//            sequences and random programs checked against an ISA-level
//            model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_multicycle;

  localparam int DATA_W = 32;
  localparam int NREG   = 4;
  localparam int ADDR_W = 16;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        MemReq, MemWe;
  logic [15:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData = '0;
  logic        MemReady = 1'b0;
  logic [3:0]  DbgSel = '0;
  logic [31:0] DbgData;
  logic [15:0] PC;
  logic [31:0] InstrAtual;
  logic        Halted, Illegal;
  logic [31:0] Retired;

  calc_multicycle #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset(Reset), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemRData(MemRData), .MemReady(MemReady), .DbgSel(DbgSel),
    .DbgData(DbgData), .PC(PC), .InstrAtual(InstrAtual), .Halted(Halted),
    .Illegal(Illegal), .Retired(Retired)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem  [0:65535];
  logic [31:0] mmem [0:65535];
  int          wait_n = 0;
  bit          idle_noise = 1'b0;
  int          wcnt = 0;
  int          cyc = 0;
  logic        p_req = 1'b0, p_we = 1'b0;
  logic [15:0] p_addr = '0;
  logic [31:0] p_wdata = '0;
  logic [15:0] wlog_addr [$];
  logic [31:0] wlog_data [$];
  bit          got_first = 1'b0;
  logic [15:0] first_fetch = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: applies accepted transfers, checks hold stability, drives ready.
  always @(negedge Clk) begin
    cyc++;
    if (!Reset && p_req && MemReady) begin
      if (p_we) begin
        mem[p_addr] = p_wdata;
        wlog_addr.push_back(p_addr);
        wlog_data.push_back(p_wdata);
      end else if (!got_first) begin
        got_first   = 1'b1;
        first_fetch = p_addr;
      end
      wcnt = 0;
    end else if (!Reset && p_req && MemReq) begin
      check("hs_stable", {15'd0, MemWe, MemAddr, MemWData}, {15'd0, p_we, p_addr, p_wdata});
    end
    if (Reset) begin
      wcnt     = 0;
      MemReady = 1'b0;
    end else if (MemReq) begin
      if (wcnt >= wait_n) begin
        MemReady = 1'b1;
        MemRData = mem[MemAddr];
      end else begin
        MemReady = 1'b0;
        MemRData = $urandom;
        wcnt++;
      end
    end else begin
      MemReady = idle_noise ? 1'($urandom) : 1'b0;
      MemRData = $urandom;
    end
    p_req   = MemReq;
    p_we    = MemWe;
    p_addr  = MemAddr;
    p_wdata = MemWData;
  end

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] a,
                                      input logic [3:0] d, input logic [19:0] imm);
    return {op, a, d, imm};
  endfunction

  task automatic start_reset();
    @(negedge Clk);
    #2 Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    wlog_addr.delete();
    wlog_data.delete();
    got_first = 1'b0;
  endtask

  task automatic end_reset();
    @(negedge Clk);
    #2 Reset = 1'b0;
  endtask

  task automatic rd(input logic [3:0] i, output logic [31:0] v);
    DbgSel = i;
    #1 v = DbgData;
  endtask

  task automatic wait_ret(input int target, input int budget, output int stamp);
    bit ok = 1'b0;
    stamp = -1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge Clk);
      #1;
      if (Retired == 32'(target)) begin
        ok = 1'b1;
        stamp = cyc;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_retired: got %0d, expected %0d", Retired, target);
    end
  endtask

  task automatic wait_halt(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge Clk);
      #1;
      if (Halted) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_halt: got Halted=%0b, expected 1", Halted);
    end
  endtask

  // ISA-level reference model: executes instructions one at a time.
  logic [31:0] m_reg [0:15];
  logic [15:0] m_pc;
  int          m_ret;
  bit          m_halt, m_ill;

  function automatic logic [31:0] mreg(input logic [3:0] i);
    return (i == 4'd0 || int'(i) >= NREG) ? 32'd0 : m_reg[i];
  endfunction

  task automatic model_run(input int k);
    logic [31:0] ins, immx, av, dv, res;
    logic [15:0] nx, ea;
    bit          wr;
    m_pc = '0; m_ret = 0; m_halt = 1'b0; m_ill = 1'b0;
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    while (!m_halt && m_ret < k) begin
      ins  = mmem[m_pc];
      immx = 32'($signed(ins[19:0]));
      av   = mreg(ins[27:24]);
      dv   = mreg(ins[23:20]);
      nx   = m_pc + 16'd1;
      ea   = 16'(av + immx);
      res  = '0;
      wr   = 1'b0;
      case (ins[31:28])
        4'h0: ;
        4'h1: begin res = av + immx; wr = 1'b1; end
        4'h2: begin res = av - immx; wr = 1'b1; end
        4'h3: begin res = av & immx; wr = 1'b1; end
        4'h4: begin res = av | immx; wr = 1'b1; end
        4'h5: begin res = av ^ immx; wr = 1'b1; end
        4'h6: begin res = mmem[ea]; wr = 1'b1; end
        4'h7: mmem[ea] = dv;
        4'h8: if (av == 0) nx = m_pc + 16'd1 + immx[15:0];
        4'h9: nx = immx[15:0];
        4'hF: m_halt = 1'b1;
        default: begin m_halt = 1'b1; m_ill = 1'b1; end
      endcase
      if (!m_halt) begin
        if (wr && ins[23:20] != 4'd0 && int'(ins[23:20]) < NREG) m_reg[ins[23:20]] = res;
        m_pc = nx;
        m_ret++;
      end
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [19:0] pre;
    logic [3:0]  chk_reg;
    logic [31:0] exp_val;
    logic [15:0] exp_pc;
    int          exp_cyc;
  } vec_t;

  vec_t        vt [15];
  logic [31:0] v;
  int          s0, s1, s2, s3;

  initial begin
    // Each vector: R1 <- pre at PC 0, then the instruction under test at PC 1.
    vt[0]  = '{enc(4'h1, 4'd1, 4'd2, 20'hFFFF9), 20'h00005, 4'd2, 32'hFFFF_FFFE, 16'd2,  3};
    vt[1]  = '{enc(4'h2, 4'd1, 4'd2, 20'h00003), 20'h00001, 4'd2, 32'hFFFF_FFFE, 16'd2,  3};
    vt[2]  = '{enc(4'h3, 4'd1, 4'd3, 20'h0F0F0), 20'h12345, 4'd3, 32'h0000_2040, 16'd2,  3};
    vt[3]  = '{enc(4'h4, 4'd1, 4'd3, 20'h80000), 20'h00001, 4'd3, 32'hFFF8_0001, 16'd2,  3};
    vt[4]  = '{enc(4'h5, 4'd1, 4'd2, 20'hFFFFF), 20'h00055, 4'd2, 32'hFFFF_FFAA, 16'd2,  3};
    vt[5]  = '{enc(4'h1, 4'd1, 4'd0, 20'h00001), 20'h00009, 4'd0, 32'h0000_0000, 16'd2,  3};
    vt[6]  = '{enc(4'h1, 4'd1, 4'd5, 20'h00001), 20'h00009, 4'd1, 32'h0000_0009, 16'd2,  3};
    vt[7]  = '{enc(4'h1, 4'd1, 4'd5, 20'h00001), 20'h00009, 4'd5, 32'h0000_0000, 16'd2,  3};
    vt[8]  = '{enc(4'h8, 4'd1, 4'd0, 20'h00003), 20'h00007, 4'd1, 32'h0000_0007, 16'd2,  3};
    vt[9]  = '{enc(4'h8, 4'd0, 4'd0, 20'h00003), 20'h00007, 4'd1, 32'h0000_0007, 16'd5,  3};
    vt[10] = '{enc(4'h9, 4'd0, 4'd0, 20'h00010), 20'h00002, 4'd1, 32'h0000_0002, 16'h10, 3};
    vt[11] = '{enc(4'h8, 4'd0, 4'd0, 20'hFFFFF), 20'h00002, 4'd1, 32'h0000_0002, 16'd1,  3};
    vt[12] = '{enc(4'h0, 4'd0, 4'd0, 20'h00000), 20'h00003, 4'd1, 32'h0000_0003, 16'd2,  3};
    vt[13] = '{enc(4'h7, 4'd1, 4'd1, 20'h00010), 20'h00030, 4'd1, 32'h0000_0030, 16'd2,  4};
    vt[14] = '{enc(4'h4, 4'd1, 4'd2, 20'h000FF), 20'h80000, 4'd2, 32'hFFF8_00FF, 16'd2,  3};

    // Test-plan program with zero wait states, cycle exact.
    start_reset();
    mem[0] = enc(4'h1, 4'd0, 4'd1, 20'd5);
    mem[1] = enc(4'h1, 4'd1, 4'd2, 20'hFFFF9);
    mem[2] = 32'hF000_0000;
    wait_n = 0;
    end_reset();
    repeat (8) @(posedge Clk);
    #1 check("prog_halted_c8", 64'(Halted), 64'd0);
    @(posedge Clk);
    #1 check("prog_halted_c9", 64'(Halted), 64'd1);
    check("prog_illegal", 64'(Illegal), 64'd0);
    check("prog_retired", 64'(Retired), 64'd2);
    check("prog_pc", 64'(PC), 64'd2);
    rd(4'd1, v); check("prog_r1", 64'(v), 64'h5);
    rd(4'd2, v); check("prog_r2", 64'(v), 64'hFFFF_FFFE);

    // Same program with three wait states on every request.
    start_reset();
    mem[0] = enc(4'h1, 4'd0, 4'd1, 20'd5);
    mem[1] = enc(4'h1, 4'd1, 4'd2, 20'hFFFF9);
    mem[2] = 32'hF000_0000;
    wait_n = 3;
    end_reset();
    wait_ret(1, 100, s1);
    wait_ret(2, 100, s2);
    check("wait_addi_cycles", 64'(s2 - s1), 64'd6);
    wait_halt(100);
    check("wait_retired", 64'(Retired), 64'd2);
    check("wait_pc", 64'(PC), 64'd2);
    rd(4'd1, v); check("wait_r1", 64'(v), 64'h5);
    rd(4'd2, v); check("wait_r2", 64'(v), 64'hFFFF_FFFE);
    wait_n = 0;

    // Store then load through the shared port.
    start_reset();
    mem[0] = enc(4'h1, 4'd0, 4'd1, 20'h01234);
    mem[1] = enc(4'h7, 4'd0, 4'd1, 20'h00040);
    mem[2] = enc(4'h6, 4'd0, 4'd3, 20'h00040);
    mem[3] = 32'hF000_0000;
    end_reset();
    wait_ret(1, 50, s1);
    wait_ret(2, 50, s2);
    wait_ret(3, 50, s3);
    check("st_cycles", 64'(s2 - s1), 64'd4);
    check("ld_cycles", 64'(s3 - s2), 64'd4);
    check("st_count", 64'(wlog_addr.size()), 64'd1);
    if (wlog_addr.size() > 0) begin
      check("st_addr", 64'(wlog_addr[0]), 64'h40);
      check("st_data", 64'(wlog_data[0]), 64'h1234);
    end
    rd(4'd3, v); check("ld_r3", 64'(v), 64'h1234);

    // Reset state after a run that left state non-zero.
    @(negedge Clk);
    #2 Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    #1;
    check("rst_pc", 64'(PC), 64'd0);
    check("rst_ir", 64'(InstrAtual), 64'd0);
    check("rst_retired", 64'(Retired), 64'd0);
    check("rst_flags", {62'd0, Halted, Illegal}, 64'd0);
    check("rst_mem", {15'd0, MemReq, MemWe, MemAddr, MemWData}, 64'd0);
    rd(4'd3, v); check("rst_r3", 64'(v), 64'd0);

    // Illegal opcode at PC 6 after six NOPs.
    start_reset();
    mem[6] = 32'hB000_0000;
    end_reset();
    wait_halt(200);
    check("ill_illegal", 64'(Illegal), 64'd1);
    check("ill_pc", 64'(PC), 64'd6);
    check("ill_retired", 64'(Retired), 64'd6);
    repeat (3) begin
      @(negedge Clk);
      #1 check("ill_memreq", {62'd0, MemReq, Halted}, 64'd1);
    end

    // Reset while a fetch is stalled.
    start_reset();
    end_reset();
    wait_ret(3, 100, s1);
    wait_n = 100;
    repeat (6) @(negedge Clk);
    #1 check("stall_state", {61'd0, MemReq, MemReady, MemWe}, 64'b100);
    check("stall_pc", 64'(PC), 64'd4);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1 check("stall_rst_req", 64'(MemReq), 64'd0);
    check("stall_rst_pc", 64'(PC), 64'd0);
    @(negedge Clk);
    wait_n = 0;
    got_first = 1'b0;
    #2 Reset = 1'b0;
    wait_ret(1, 50, s1);
    check("stall_first_fetch", 64'(first_fetch), 64'd0);

    // Table-driven single-instruction vectors.
    foreach (vt[i]) begin
      start_reset();
      mem[0] = enc(4'h1, 4'd0, 4'd1, vt[i].pre);
      mem[1] = vt[i].instr;
      end_reset();
      wait_ret(1, 50, s1);
      wait_ret(2, 50, s2);
      check($sformatf("vec%0d_cycles", i), 64'(s2 - s1), 64'(vt[i].exp_cyc));
      check($sformatf("vec%0d_pc", i), 64'(PC), 64'(vt[i].exp_pc));
      rd(vt[i].chk_reg, v);
      check($sformatf("vec%0d_reg", i), 64'(v), 64'(vt[i].exp_val));
    end

    // Random programs against the ISA model, random waits and idle ready noise.
    idle_noise = 1'b1;
    for (int run = 0; run < 6; run++) begin
      start_reset();
      for (int a = 0; a < 32; a++) begin
        logic [3:0]  op;
        logic [19:0] imm;
        op = 4'($urandom_range(0, 9));
        case (op)
          4'h8:        imm = 20'($urandom_range(0, 8)) - 20'd4;
          4'h9:        imm = 20'($urandom_range(0, 31));
          4'h6, 4'h7:  imm = 20'($urandom_range(64, 95));
          default:     imm = 20'($urandom);
        endcase
        mem[a] = enc(op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), imm);
      end
      for (int a = 0; a < 65536; a++) mmem[a] = mem[a];
      wait_n = $urandom_range(0, 2);
      model_run(40);
      end_reset();
      if (m_halt) wait_halt(2000);
      else wait_ret(m_ret, 2000, s0);
      check($sformatf("rnd%0d_retired", run), 64'(Retired), 64'(m_ret));
      check($sformatf("rnd%0d_pc", run), 64'(PC), 64'(m_pc));
      check($sformatf("rnd%0d_flags", run), {62'd0, Halted, Illegal}, {62'd0, m_halt, m_ill});
      for (int r = 1; r < 8; r++) begin
        rd(4'(r), v);
        check($sformatf("rnd%0d_r%0d", run, r), 64'(v), 64'(mreg(4'(r))));
      end
    end
    idle_noise = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
